// File: rtl/palette_lut.sv
// palette_lut: programmable colour-index to RGB lookup with default-reload sequencer,
// blanking override and transparency flag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pix_valid_i       pixel index valid
//   pix_index_i       colour index from the compositor
//   blank_i           blanking interval, forces black
//   wr_en_i           palette write strobe
//   wr_addr_i         palette write address
//   wr_data_i         palette write data (R in [23:16])
//   reload_i          pulse: restore the default palette
//   fade_level_i      (PALETTE_FADE_EN only) brightness level, 8 = full
//   fade_load_i       (PALETTE_FADE_EN only) latch fade_level_i
//   busy_o            reload in progress
//   wr_drop_o         one-cycle pulse: a write was discarded
//   pix_valid_o       output valid (latency 2, or 3 with PALETTE_FADE_EN)
//   rgb_o             RGB colour
//   transp_o          output pixel is the transparent index
//
// Optional feature macro: PALETTE_FADE_EN adds a brightness-scaling third stage.
module palette_lut #(
    parameter int          INDEX_W    = 6,
    parameter int unsigned DEPTH      = 64,
    parameter int          COLOR_W    = 24,
    parameter int unsigned TRANSP_IDX = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid_i,
    input  logic [INDEX_W-1:0] pix_index_i,
    input  logic               blank_i,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic               reload_i,
`ifdef PALETTE_FADE_EN
    input  logic [3:0]         fade_level_i,
    input  logic               fade_load_i,
`endif
    output logic               busy_o,
    output logic               wr_drop_o,
    output logic               pix_valid_o,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               transp_o
);
    typedef enum logic {S_IDLE, S_RELOAD} state_t;

    localparam logic [23:0] DEF [20] = '{
        24'h000000, 24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFFC9A1,
        24'h0000FF, 24'hFFFD00, 24'hFF0098, 24'h363636, 24'hD91818,
        24'hD96518, 24'h220404, 24'h9F1212, 24'h4B0909, 24'h2ACBC1,
        24'hFDA24A, 24'hFD6E44, 24'hFFFD74, 24'hFDD761, 24'hFFFED2
    };

    state_t             r_state;
    logic [INDEX_W-1:0] r_cnt;
    logic [COLOR_W-1:0] r_pal [DEPTH];
    logic               r_s1_valid;
    logic [INDEX_W-1:0] r_s1_idx;
    logic               r_s1_blank;
    logic               r_valid;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_transp;
    logic               r_drop;

    logic               w_busy;
    logic               w_wr_ok;
    logic               w_kill;
    logic [COLOR_W-1:0] w_def;
    logic [COLOR_W-1:0] w_rgb;
    logic               w_transp;

    always_comb begin
        w_busy   = (r_state == S_RELOAD);
        w_wr_ok  = 32'(wr_addr_i) < DEPTH;
        w_def    = (32'(r_cnt) < 32'd20) ? COLOR_W'(DEF[r_cnt[4:0]]) : '0;
        w_kill   = r_s1_blank | w_busy;
        // array read happens before this edge's write lands, so a write on edge 2 is not seen
        w_rgb    = (w_kill || 32'(r_s1_idx) >= DEPTH) ? '0 : r_pal[r_s1_idx];
        w_transp = !w_kill && (32'(r_s1_idx) == TRANSP_IDX);
    end

    // reload sequencer: one default entry per cycle, DEPTH cycles total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RELOAD;
            r_cnt   <= '0;
        end else if (r_state == S_RELOAD) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == INDEX_W'(DEPTH - 1)) r_state <= S_IDLE;
        end else if (reload_i) begin
            r_state <= S_RELOAD;
            r_cnt   <= '0;
        end
    end

    // palette storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_busy) r_pal[r_cnt] <= w_def;
        else if (wr_en_i && w_wr_ok) r_pal[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_blank <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_s1_valid <= pix_valid_i;
            r_s1_idx   <= pix_index_i;
            r_s1_blank <= blank_i;
            r_drop     <= wr_en_i & (w_busy | ~w_wr_ok);
        end
    end

`ifdef PALETTE_FADE_EN
    logic [3:0]         r_level;
    logic               r_s2_valid;
    logic [COLOR_W-1:0] r_s2_rgb;
    logic               r_s2_transp;
    logic [3:0]         w_lvl;
    logic [COLOR_W-1:0] w_scaled;

    always_comb begin
        w_lvl    = (r_level > 4'd8) ? 4'd8 : r_level;
        w_scaled = '0;
        for (int c = 0; c < 3; c++)
            w_scaled[c*8 +: 8] = 8'((12'(r_s2_rgb[c*8 +: 8]) * 12'(w_lvl)) >> 3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= 4'd8;
            r_s2_valid  <= 1'b0;
            r_s2_rgb    <= '0;
            r_s2_transp <= 1'b0;
            r_valid     <= 1'b0;
            r_rgb       <= '0;
            r_transp    <= 1'b0;
        end else begin
            if (fade_load_i) r_level <= fade_level_i;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_rgb    <= w_rgb;
                r_s2_transp <= w_transp;
            end
            r_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_rgb    <= w_scaled;
                r_transp <= r_s2_transp;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_rgb    <= '0;
            r_transp <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb    <= w_rgb;
                r_transp <= w_transp;
            end
        end
    end
`endif

    assign busy_o      = w_busy;
    assign wr_drop_o   = r_drop;
    assign pix_valid_o = r_valid;
    assign rgb_o       = r_rgb;
    assign transp_o    = r_transp;
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed and randomized checks of palette_lut against a behavioural model.
module tb_palette_lut;
    localparam int IW    = 6;
    localparam int DEPTH = 48;
    localparam int CW    = 24;
    localparam int TIDX  = 0;

    localparam logic [23:0] DEF_TB [20] = '{
        24'h000000, 24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFFC9A1,
        24'h0000FF, 24'hFFFD00, 24'hFF0098, 24'h363636, 24'hD91818,
        24'hD96518, 24'h220404, 24'h9F1212, 24'h4B0909, 24'h2ACBC1,
        24'hFDA24A, 24'hFD6E44, 24'hFFFD74, 24'hFDD761, 24'hFFFED2
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid_i = 1'b0;
    logic [IW-1:0] pix_index_i = '0;
    logic          blank_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [IW-1:0] wr_addr_i = '0;
    logic [CW-1:0] wr_data_i = '0;
    logic          reload_i = 1'b0;
    logic          busy_o, wr_drop_o, pix_valid_o, transp_o;
    logic [CW-1:0] rgb_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] m_pal [64];
    int          m_left;
    bit          m_s1_v, m_s1_b;
    int          m_s1_i;
    logic [23:0] e_rgb;
    bit          e_v, e_tr, e_drop;

    palette_lut #(.INDEX_W(IW), .DEPTH(DEPTH), .COLOR_W(CW), .TRANSP_IDX(TIDX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid_i(pix_valid_i), .pix_index_i(pix_index_i), .blank_i(blank_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .reload_i(reload_i), .busy_o(busy_o), .wr_drop_o(wr_drop_o),
        .pix_valid_o(pix_valid_o), .rgb_o(rgb_o), .transp_o(transp_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] def_of(input int i);
        return (i < 20) ? DEF_TB[i] : 24'h0;
    endfunction

    task automatic model_reset();
        m_left = DEPTH;
        m_s1_v = 0; m_s1_b = 0; m_s1_i = 0;
        e_rgb = '0; e_v = 0; e_tr = 0; e_drop = 0;
    endtask

    // one clock edge: output stage sees the palette as it was before this edge's write
    task automatic model_edge();
        bit busy;
        int a;
        busy = m_left > 0;
        a = int'(wr_addr_i);
        if (m_s1_v) begin
            e_rgb = (m_s1_b || busy || m_s1_i >= DEPTH) ? 24'h0 : m_pal[m_s1_i];
            e_tr  = !(m_s1_b || busy) && m_s1_i == TIDX;
        end
        e_v = m_s1_v;
        m_s1_v = pix_valid_i; m_s1_b = blank_i; m_s1_i = int'(pix_index_i);
        e_drop = wr_en_i && (busy || a >= DEPTH);
        if (busy) begin
            m_pal[DEPTH - m_left] = def_of(DEPTH - m_left);
            m_left--;
        end else begin
            if (wr_en_i && a < DEPTH) m_pal[a] = wr_data_i;
            if (reload_i) m_left = DEPTH;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", 32'(busy_o), 32'(m_left > 0));
        check("drop", 32'(wr_drop_o), 32'(e_drop));
        check("valid", 32'(pix_valid_o), 32'(e_v));
        check("rgb", 32'(rgb_o), 32'(e_rgb));
        check("transp", 32'(transp_o), 32'(e_tr));
    endtask

    task automatic idle_in();
        pix_valid_i = 0; blank_i = 0; wr_en_i = 0; reload_i = 0;
    endtask

    task automatic pix(input int idx, input bit blk);
        pix_valid_i = 1; pix_index_i = IW'(idx); blank_i = blk;
        step();
        idle_in();
        step();
    endtask

    task automatic do_reload();
        reload_i = 1;
        step();
        idle_in();
        repeat (DEPTH + 2) step();
    endtask

    initial begin
        int bc;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd1);
        check("rst_valid", 32'(pix_valid_o), 32'd0);
        check("rst_rgb", 32'(rgb_o), 32'd0);
        check("rst_transp", 32'(transp_o), 32'd0);
        check("rst_drop", 32'(wr_drop_o), 32'd0);
        rst_n = 1;
        bc = 0;
        for (int k = 0; k < DEPTH + 10; k++) begin
            if (busy_o) bc++;
            step();
        end
        check("busy_len", 32'(bc), 32'(DEPTH));

        pix(3, 0);
        check("idx3_rgb", 32'(rgb_o), 32'hFF0000);
        check("idx3_valid", 32'(pix_valid_o), 32'd1);

        wr_en_i = 1; wr_addr_i = 14; wr_data_i = 24'h123456;
        step();
        idle_in();
        pix(14, 0);
        check("wr14", 32'(rgb_o), 32'h123456);
        do_reload();
        pix(14, 0);
        check("reload14", 32'(rgb_o), 32'h2ACBC1);

        wr_en_i = 1; wr_addr_i = 5; wr_data_i = 24'hABCDEF;
        pix(5, 0);
        check("wr_same_edge", 32'(rgb_o), 32'hABCDEF);
        do_reload();
        pix_valid_i = 1; pix_index_i = 5;
        step();
        idle_in();
        wr_en_i = 1; wr_addr_i = 5; wr_data_i = 24'hABCDEF;
        step();
        idle_in();
        check("wr_late_edge", 32'(rgb_o), 32'h0000FF);
        step();

        reload_i = 1;
        step();
        idle_in();
        wr_en_i = 1; wr_addr_i = 7; wr_data_i = 24'h555555;
        step();
        idle_in();
        check("drop_busy", 32'(wr_drop_o), 32'd1);
        step();
        check("drop_busy_end", 32'(wr_drop_o), 32'd0);
        repeat (DEPTH) step();
        wr_en_i = 1; wr_addr_i = 50; wr_data_i = 24'h777777;
        step();
        idle_in();
        check("drop_range", 32'(wr_drop_o), 32'd1);
        step();
        check("drop_range_end", 32'(wr_drop_o), 32'd0);
        pix(7, 0);
        check("idx7_kept", 32'(rgb_o), 32'hFF0098);
        pix(50, 0);
        check("idx_oob", 32'(rgb_o), 32'd0);
        pix(25, 0);
        check("idx25", 32'(rgb_o), 32'd0);

        pix(0, 0);
        check("transp0", 32'(transp_o), 32'd1);
        check("transp0_rgb", 32'(rgb_o), 32'd0);
        pix(2, 1);
        check("blank_rgb", 32'(rgb_o), 32'd0);
        check("blank_transp", 32'(transp_o), 32'd0);
        pix(2, 0);
        check("idx2", 32'(rgb_o), 32'hFFFFFF);

        reload_i = 1;
        step();
        idle_in();
        repeat (10) step();
        rst_n = 0;
        #1;
        model_reset();
        check("midrst_busy", 32'(busy_o), 32'd1);
        check("midrst_valid", 32'(pix_valid_o), 32'd0);
        check("midrst_rgb", 32'(rgb_o), 32'd0);
        @(negedge clk);
        rst_n = 1;
        bc = 0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (busy_o) bc++;
            step();
        end
        check("midrst_busy_len", 32'(bc), 32'(DEPTH));
        pix(4, 0);
        check("idx4", 32'(rgb_o), 32'hFFC9A1);

        repeat (3000) begin
            pix_valid_i = 1'($urandom_range(0, 1));
            pix_index_i = IW'($urandom_range(0, 63));
            blank_i     = ($urandom_range(0, 7) == 0);
            wr_en_i     = ($urandom_range(0, 3) == 0);
            wr_addr_i   = IW'($urandom_range(0, 63));
            wr_data_i   = CW'($urandom());
            reload_i    = ($urandom_range(0, 99) == 0);
            step();
        end
        idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
